// File: rtl/adc_align_pkg.sv
// Shared definitions for the ADC valid aligner: default sizing, the lane
// state encoding and the latency range check used by every lane.
package adc_align_pkg;

    localparam int MAX_LAT_DEF = 64;
    localparam int LAT_W_DEF   = 7;

    // A lane is either waiting for a burst or inside one.
    typedef enum logic {
        LANE_IDLE = 1'b0,
        LANE_RUN  = 1'b1
    } lane_state_e;

    // A latency is usable when it selects an existing delay-line tap:
    // 1..max inclusive. Zero would need a tap before the newest bit.
    function automatic logic lat_ok(input logic [31:0] lat, input logic [31:0] max);
        return (lat != 32'd0) && (lat <= max);
    endfunction

endpackage

// File: rtl/adc_valid_aligner_if.sv
// Bundle between the readout sequencer side and the aligner.
//
// Handshake: there is no backpressure. dat_valid[c] qualifies dat_out lane c
// in the cycle it is high; the consumer must accept every valid word. sop[c]
// is only ever high together with dat_valid[c]. burst_done[c] is high for one
// cycle, on the first cycle after the burst's last valid word, and burst_len
// lane c is stable from that cycle until the next burst_done[c].
// lane_run exposes each lane FSM (1 = inside a burst) for observation.
interface adc_valid_aligner_if #(
    parameter int N_CH  = 2,
    parameter int DW    = 14,
    parameter int LAT_W = 7,
    parameter int CW    = 12
);
    logic                  adc_rd;
    logic [N_CH*LAT_W-1:0] tlat;
    logic [N_CH*DW-1:0]    adc_data;
    logic [N_CH*DW-1:0]    dat_out;
    logic [N_CH-1:0]       dat_valid;
    logic [N_CH-1:0]       sop;
    logic [N_CH-1:0]       burst_done;
    logic [N_CH*CW-1:0]    burst_len;
    logic [N_CH-1:0]       lat_err;
    logic [N_CH-1:0]       lane_run;

    modport master (
        output adc_rd, tlat, adc_data,
        input  dat_out, dat_valid, sop, burst_done, burst_len, lat_err, lane_run
    );

    modport slave (
        input  adc_rd, tlat, adc_data,
        output dat_out, dat_valid, sop, burst_done, burst_len, lat_err, lane_run
    );
endinterface

// File: rtl/adc_valid_lane.sv
// One aligner channel: latency shadow register, tap selection from the shared
// delay line, registered data/valid, and the burst FSM with its word counter.
module adc_valid_lane
    import adc_align_pkg::*;
#(
    parameter int DW      = 14,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LAT_W   = LAT_W_DEF,
    parameter int CW      = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               line_idle_i,
    input  logic [MAX_LAT-1:0] dly_i,
    input  logic [LAT_W-1:0]   tlat_i,
    input  logic [DW-1:0]      data_i,
    output logic [DW-1:0]      dat_out_o,
    output logic               dat_valid_o,
    output logic               sop_o,
    output logic               burst_done_o,
    output logic [CW-1:0]      burst_len_o,
    output logic               lat_err_o,
    output lane_state_e        state_o
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [LAT_W-1:0] lat_q;
    logic             lat_err;
    logic             tap;

    lane_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    len_q, len_d;
    logic             sop_q, sop_d;
    logic             done_q, done_d;
    logic             valid_q;
    logic [DW-1:0]    dout_q;

    assign lat_err = !lat_ok(32'(lat_q), 32'(MAX_LAT));

    // Latency shadow: captured during reset, otherwise only while nothing is
    // in flight, so a new latency can never cut or stretch a valid window.
    always_ff @(posedge clk_i) begin
        if (rst_i || (line_idle_i && !valid_q)) begin
            lat_q <= tlat_i;
        end
    end

    // Tap select: latency L picks dly[L-1]; an out-of-range latency gives no
    // tap at all rather than a substitute one.
    always_comb begin
        tap = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (lat_q == LAT_W'(i + 1)) begin
                tap = dly_i[i];
            end
        end
        if (lat_err) begin
            tap = 1'b0;
        end
    end

    // Burst FSM next state: start on a rising tap, count while it stays high,
    // publish the count when it falls. Pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sop_d   = 1'b0;
        done_d  = 1'b0;
        if (lat_err) begin
            state_d = LANE_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LANE_IDLE: begin
                    if (tap) begin
                        state_d = LANE_RUN;
                        sop_d   = 1'b1;
                        cnt_d   = CW'(1);
                    end
                end
                LANE_RUN: begin
                    if (tap) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = LANE_IDLE;
                        len_d   = cnt_q;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LANE_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM and burst bookkeeping registers; reset aborts a burst silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LANE_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sop_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sop_q   <= sop_d;
            done_q  <= done_d;
        end
    end

    // Output data path: valid follows the tap, data is registered every cycle
    // whether or not it is valid so both see the same one-cycle delay.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= tap;
            dout_q  <= data_i;
        end
    end

    assign dat_out_o    = dout_q;
    assign dat_valid_o  = valid_q;
    assign sop_o        = sop_q;
    assign burst_done_o = done_q;
    assign burst_len_o  = len_q;
    assign lat_err_o    = lat_err;
    assign state_o      = state_q;

endmodule

// File: rtl/adc_valid_aligner.sv
// Multi-channel ADC data-valid aligner. Resynchronises the sequencer's read
// strobe into adc1_out_clk, feeds one shared delay line, and lets each
// channel tap it at its own latency. LAT_W must satisfy 2**LAT_W > MAX_LAT.
module adc_valid_aligner
    import adc_align_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DW      = 14,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int LAT_W   = LAT_W_DEF,
    parameter int CW      = 12
) (
    input  logic                adc1_out_clk,
    input  logic                rst,
    adc_valid_aligner_if.slave  bus
);

    logic               s1_q;
    logic               s2_q;
    logic [MAX_LAT-1:0] dly_q;
    logic               line_idle;

    logic [N_CH*DW-1:0] dat_out;
    logic [N_CH-1:0]    dat_valid;
    logic [N_CH-1:0]    sop;
    logic [N_CH-1:0]    burst_done;
    logic [N_CH*CW-1:0] burst_len;
    logic [N_CH-1:0]    lat_err;
    logic [N_CH-1:0]    lane_run;

    // Two-flop resync of the asynchronous strobe, then a shift line where
    // bit 0 holds the newest synchronised sample.
    always_ff @(posedge adc1_out_clk) begin
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dly_q <= '0;
        end else begin
            s1_q  <= bus.adc_rd;
            s2_q  <= s1_q;
            dly_q <= {dly_q[MAX_LAT-2:0], s2_q};
        end
    end

    // Nothing is travelling through the synchroniser or the delay line.
    assign line_idle = !s1_q && !s2_q && (dly_q == '0);

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        lane_state_e lane_state;

        adc_valid_lane #(
            .DW      (DW),
            .MAX_LAT (MAX_LAT),
            .LAT_W   (LAT_W),
            .CW      (CW)
        ) u_lane (
            .clk_i        (adc1_out_clk),
            .rst_i        (rst),
            .line_idle_i  (line_idle),
            .dly_i        (dly_q),
            .tlat_i       (bus.tlat[c*LAT_W +: LAT_W]),
            .data_i       (bus.adc_data[c*DW +: DW]),
            .dat_out_o    (dat_out[c*DW +: DW]),
            .dat_valid_o  (dat_valid[c]),
            .sop_o        (sop[c]),
            .burst_done_o (burst_done[c]),
            .burst_len_o  (burst_len[c*CW +: CW]),
            .lat_err_o    (lat_err[c]),
            .state_o      (lane_state)
        );

        assign lane_run[c] = (lane_state == LANE_RUN);
    end

    assign bus.dat_out    = dat_out;
    assign bus.dat_valid  = dat_valid;
    assign bus.sop        = sop;
    assign bus.burst_done = burst_done;
    assign bus.burst_len  = burst_len;
    assign bus.lat_err    = lat_err;
    assign bus.lane_run   = lane_run;

endmodule

// File: tb/tb_adc_valid_aligner.sv
// Bench for adc_valid_aligner: directed scenarios plus random bursts, with a
// reference model that derives each output from the strobe history
// ("valid now = strobe sampled L+2 edges ago"). A second instance with a
// 4-bit counter shares all inputs to exercise saturation.
module tb_adc_valid_aligner;

    localparam int N_CH    = 2;
    localparam int DW      = 14;
    localparam int MAX_LAT = 64;
    localparam int LAT_W   = 7;
    localparam int CW      = 12;
    localparam int CWB     = 4;
    localparam int HIST    = MAX_LAT + 2;

    logic                  clk;
    logic                  rst;
    logic                  adc_rd;
    logic [N_CH*LAT_W-1:0] tlat;
    logic [N_CH*DW-1:0]    adc_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    adc_valid_aligner_if #(.N_CH(N_CH), .DW(DW), .LAT_W(LAT_W), .CW(CW))  bus_a ();
    adc_valid_aligner_if #(.N_CH(N_CH), .DW(DW), .LAT_W(LAT_W), .CW(CWB)) bus_b ();

    assign bus_a.adc_rd   = adc_rd;
    assign bus_a.tlat     = tlat;
    assign bus_a.adc_data = adc_data;
    assign bus_b.adc_rd   = adc_rd;
    assign bus_b.tlat     = tlat;
    assign bus_b.adc_data = adc_data;

    adc_valid_aligner #(.N_CH(N_CH), .DW(DW), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .CW(CW)) dut_a (
        .adc1_out_clk (clk),
        .rst          (rst),
        .bus          (bus_a)
    );

    adc_valid_aligner #(.N_CH(N_CH), .DW(DW), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W), .CW(CWB)) dut_b (
        .adc1_out_clk (clk),
        .rst          (rst),
        .bus          (bus_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic          hist_q[$];
    int            m_lat   [N_CH];
    logic          m_valid [N_CH];
    logic          m_sop   [N_CH];
    logic          m_done  [N_CH];
    int            m_run   [N_CH];
    int            m_len   [N_CH];
    logic [DW-1:0] m_dout  [N_CH];

    // observations of dut_a for directed checks
    logic obs_prev [N_CH];
    int   rise     [N_CH];
    int   vwid     [N_CH];
    int   sop_n    [N_CH];
    int   done_n   [N_CH];
    int   lens0    [$];
    int   lens1    [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic lat_in_range(input int l);
        return (l >= 1) && (l <= MAX_LAT);
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [N_CH*LAT_W-1:0] pack_lat(input int l0, input int l1);
        logic [LAT_W-1:0] a;
        logic [LAT_W-1:0] b;
        a = LAT_W'(l0);
        b = LAT_W'(l1);
        return {b, a};
    endfunction

    // Advance the model by one edge using the inputs that edge sampled.
    task automatic model_edge(input logic rst_v, input logic rd_v,
                              input logic [N_CH*LAT_W-1:0] tlat_v,
                              input logic [N_CH*DW-1:0] data_v);
        logic quiet;
        logic tap;
        if (rst_v) begin
            hist_q.delete();
            repeat (HIST) hist_q.push_back(1'b0);
            for (int c = 0; c < N_CH; c++) begin
                m_lat[c]   = int'(tlat_v[c*LAT_W +: LAT_W]);
                m_valid[c] = 1'b0;
                m_sop[c]   = 1'b0;
                m_done[c]  = 1'b0;
                m_run[c]   = 0;
                m_len[c]   = 0;
                m_dout[c]  = '0;
            end
        end else begin
            quiet = 1'b1;
            foreach (hist_q[i]) if (hist_q[i]) quiet = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                // hist_q[k] is the strobe sampled k+1 edges ago
                tap = lat_in_range(m_lat[c]) ? hist_q[m_lat[c] + 1] : 1'b0;
                m_sop[c]  = tap && !m_valid[c];
                m_done[c] = !tap && m_valid[c];
                if (m_done[c]) m_len[c] = m_run[c];
                m_run[c] = tap ? m_run[c] + 1 : 0;
                if (quiet && !m_valid[c]) m_lat[c] = int'(tlat_v[c*LAT_W +: LAT_W]);
                m_valid[c] = tap;
                m_dout[c]  = data_v[c*DW +: DW];
            end
            hist_q.push_front(rd_v);
            void'(hist_q.pop_back());
        end
    endtask

    // One clock: wait for the edge, sample #1 later, update model, compare.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_edge(rst, adc_rd, tlat, adc_data);
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("valid c%0d cyc%0d", c, cyc), 32'(bus_a.dat_valid[c]), 32'(m_valid[c]));
            check($sformatf("sop c%0d cyc%0d", c, cyc), 32'(bus_a.sop[c]), 32'(m_sop[c]));
            check($sformatf("done c%0d cyc%0d", c, cyc), 32'(bus_a.burst_done[c]), 32'(m_done[c]));
            check($sformatf("lat_err c%0d cyc%0d", c, cyc), 32'(bus_a.lat_err[c]),
                  32'(!lat_in_range(m_lat[c])));
            check($sformatf("dat_out c%0d cyc%0d", c, cyc), 32'(bus_a.dat_out[c*DW +: DW]), 32'(m_dout[c]));
            check($sformatf("len c%0d cyc%0d", c, cyc), 32'(bus_a.burst_len[c*CW +: CW]),
                  32'(min_int(m_len[c], 4095)));
            check($sformatf("run c%0d cyc%0d", c, cyc), 32'(bus_a.lane_run[c]), 32'(m_valid[c]));
            check($sformatf("len4 c%0d cyc%0d", c, cyc), 32'(bus_b.burst_len[c*CWB +: CWB]),
                  32'(min_int(m_len[c], 15)));
            if (bus_a.dat_valid[c] && !obs_prev[c]) rise[c] = cyc;
            if (bus_a.dat_valid[c]) vwid[c]++;
            if (bus_a.sop[c]) sop_n[c]++;
            if (bus_a.burst_done[c]) begin
                done_n[c]++;
                if (c == 0) lens0.push_back(int'(bus_a.burst_len[0 +: CW]));
                else        lens1.push_back(int'(bus_a.burst_len[CW +: CW]));
            end
            obs_prev[c] = bus_a.dat_valid[c];
        end
    endtask

    // driver: n clocks with fresh random ADC words
    task automatic run(input int n);
        repeat (n) begin
            adc_data = N_CH*DW'($urandom);
            step();
        end
    endtask

    task automatic clear_obs();
        for (int c = 0; c < N_CH; c++) begin
            rise[c]   = -1;
            vwid[c]   = 0;
            sop_n[c]  = 0;
            done_n[c] = 0;
        end
        lens0.delete();
        lens1.delete();
    endtask

    int e;
    int l0;
    int l1;

    initial begin
        for (int c = 0; c < N_CH; c++) obs_prev[c] = 1'b0;
        clear_obs();
        rst      = 1'b1;
        adc_rd   = 1'b0;
        adc_data = '0;
        tlat     = pack_lat(21, 32);
        run(3);
        check("reset valid", 32'(bus_a.dat_valid), 32'd0);
        check("reset lat_err", 32'(bus_a.lat_err), 32'd0);
        check("reset burst_len", 32'(bus_a.burst_len), 32'd0);
        rst = 1'b0;
        run(5);

        // basic delay, tlat = {21, 32}
        clear_obs();
        e = cyc + 1;
        adc_rd = 1'b1;
        run(100);
        adc_rd = 1'b0;
        run(120);
        check("basic rise c0", 32'(rise[0]), 32'(e + 23));
        check("basic rise c1", 32'(rise[1]), 32'(e + 34));
        check("basic width c0", 32'(vwid[0]), 32'd100);
        check("basic width c1", 32'(vwid[1]), 32'd100);
        check("basic sop c0", 32'(sop_n[0]), 32'd1);
        check("basic sop c1", 32'(sop_n[1]), 32'd1);
        check("basic done c1", 32'(done_n[1]), 32'd1);
        check("basic len c0", 32'(lens0.size() > 0 ? lens0[0] : -1), 32'd100);
        check("basic len c1", 32'(lens1.size() > 0 ? lens1[0] : -1), 32'd100);

        // range errors, tlat = {0, 65}
        tlat = pack_lat(0, 65);
        run(2);
        check("range lat_err", 32'(bus_a.lat_err), 32'd3);
        clear_obs();
        adc_rd = 1'b1;
        run(20);
        adc_rd = 1'b0;
        run(90);
        check("range valid c0", 32'(vwid[0]), 32'd0);
        check("range valid c1", 32'(vwid[1]), 32'd0);
        check("range sop", 32'(sop_n[0] + sop_n[1]), 32'd0);
        check("range done", 32'(done_n[0] + done_n[1]), 32'd0);

        // longest latency
        tlat = pack_lat(64, 64);
        run(2);
        check("max lat_err", 32'(bus_a.lat_err), 32'd0);
        clear_obs();
        e = cyc + 1;
        adc_rd = 1'b1;
        run(10);
        adc_rd = 1'b0;
        run(90);
        check("max rise c0", 32'(rise[0]), 32'(e + 66));
        check("max width c1", 32'(vwid[1]), 32'd10);

        // latency change in the middle of a burst
        tlat = pack_lat(25, 25);
        run(2);
        clear_obs();
        e = cyc + 1;
        adc_rd = 1'b1;
        run(30);
        tlat = pack_lat(30, 30);
        run(10);
        adc_rd = 1'b0;
        run(80);
        check("midchg rise c0", 32'(rise[0]), 32'(e + 27));
        check("midchg len c0", 32'(lens0.size() > 0 ? lens0[0] : -1), 32'd40);
        clear_obs();
        e = cyc + 1;
        adc_rd = 1'b1;
        run(15);
        adc_rd = 1'b0;
        run(80);
        check("midchg next rise c1", 32'(rise[1]), 32'(e + 32));
        check("midchg next len c1", 32'(lens1.size() > 0 ? lens1[0] : -1), 32'd15);

        // back-to-back bursts with a one-cycle gap
        tlat = pack_lat(3, 7);
        run(2);
        clear_obs();
        adc_rd = 1'b1;
        run(10);
        adc_rd = 1'b0;
        run(1);
        adc_rd = 1'b1;
        run(10);
        adc_rd = 1'b0;
        run(40);
        check("b2b sop c0", 32'(sop_n[0]), 32'd2);
        check("b2b done c1", 32'(done_n[1]), 32'd2);
        check("b2b len0 c0", 32'(lens0.size() > 1 ? lens0[0] : -1), 32'd10);
        check("b2b len1 c0", 32'(lens0.size() > 1 ? lens0[1] : -1), 32'd10);

        // reset in the middle of a burst
        tlat = pack_lat(4, 4);
        run(2);
        clear_obs();
        adc_rd = 1'b1;
        run(20);
        rst = 1'b1;
        adc_rd = 1'b0;
        run(1);
        check("rst mid valid", 32'(bus_a.dat_valid), 32'd0);
        check("rst mid dat_out", 32'(bus_a.dat_out), 32'd0);
        check("rst mid len", 32'(bus_a.burst_len), 32'd0);
        rst = 1'b0;
        run(30);
        check("rst mid no done", 32'(done_n[0] + done_n[1]), 32'd0);
        check("rst mid sop", 32'(sop_n[0]), 32'd1);

        // counter saturation on the 4-bit instance
        tlat = pack_lat(2, 2);
        run(2);
        clear_obs();
        adc_rd = 1'b1;
        run(40);
        adc_rd = 1'b0;
        run(10);
        check("sat len4 c0", 32'(bus_b.burst_len[0 +: CWB]), 32'd15);
        check("sat len12 c0", 32'(bus_a.burst_len[0 +: CW]), 32'd40);

        // random bursts, latencies and mid-burst latency changes
        for (int b = 0; b < 8; b++) begin
            l0 = ($urandom_range(0, 5) == 0) ? 65 : $urandom_range(1, MAX_LAT);
            l1 = ($urandom_range(0, 5) == 0) ? 0  : $urandom_range(1, MAX_LAT);
            tlat = pack_lat(l0, l1);
            run(2);
            repeat ($urandom_range(1, 3)) begin
                adc_rd = 1'b1;
                run($urandom_range(1, 30));
                if ($urandom_range(0, 1) == 1) tlat = pack_lat($urandom_range(1, MAX_LAT), l1);
                adc_rd = 1'b0;
                run($urandom_range(1, 4));
            end
            run(70);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_valid_aligner.md
# adc_valid_aligner

Parametrised, multi-channel successor to the single-pair ADC data-valid delay logic in the readout path. It sits in the ADC output clock domain between the readout sequencer and the image FIFO. It synchronises the sequencer's `adc_rd` strobe and delays it per channel by a programmable pipeline latency. It then emits aligned data/valid with start-of-burst markers and per-burst word counts. Latency changes take effect only between bursts, so a valid window is never glitched.

## Interface
Parameters:
- `N_CH`, 2: number of ADC channels.
- `DW`, 14: ADC data width per channel.
- `MAX_LAT`, 64: longest supported latency in cycles; sets the delay-line depth.
- `LAT_W`, 7: latency field width; must satisfy 2^LAT_W > MAX_LAT.
- `CW`, 12: burst word-counter width.

Ports:
- `adc1_out_clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `adc_rd`, in, 1: read-window strobe from the sequencer clock domain; asynchronous to `adc1_out_clk`.
- `tlat`, in, N_CH*LAT_W: per-channel latency; channel c is at `[c*LAT_W +: LAT_W]`.
- `adc_data`, in, N_CH*DW: raw ADC words.
- `dat_out`, out, N_CH*DW: registered data.
- `dat_valid`, out, N_CH: aligned valid per channel.
- `sop`, out, N_CH: high with the first valid word of each burst.
- `burst_done`, out, N_CH: 1-cycle pulse after a burst ends.
- `burst_len`, out, N_CH*CW: word count of the last completed burst.
- `lat_err`, out, N_CH: the active latency is out of range.

## Operation
- **Synchroniser.** Two flops `s1`, `s2` resync `adc_rd`. A single shared delay line `dly[MAX_LAT-1:0]` shifts in `s2`; bit 0 is the newest.
- **Latency shadow.** Each channel has `lat_q[c]`.
  - During `rst`, `lat_q[c]` loads `tlat[c]`.
  - After reset, `lat_q[c]` loads `tlat[c]` only while the line is idle: `s1==0`, `s2==0`, `dly==0` and `dat_valid[c]==0`.
  - A `tlat` change during a burst is held until idle.
- **Range check.** `lat_err[c] = (lat_q[c]==0) || (lat_q[c]>MAX_LAT)`.
  - If set, `dat_valid[c]`, `sop[c]` and `burst_done[c]` are forced 0.
  - The counter is also held at 0.
  - The channel never falls back to a default tap.
- **Tap.** `tap[c] = dly[lat_q[c]-1]`. Registered each cycle: `dat_valid[c] <= tap[c] & ~lat_err[c]` and `dat_out[c] <= adc_data[c]` (always, regardless of valid).
- **Per-channel lane FSM.** States IDLE, RUN.
  - IDLE→RUN when `tap[c]` is 1 (and `lat_err[c]` is 0). On that edge: `sop[c] <= 1` and `cnt <= 1`.
  - RUN, `tap[c]` stays 1: `cnt <= cnt+1`, saturating at 2^CW−1.
  - RUN→IDLE when `tap[c]` is 0. On that edge: `burst_len[c] <= cnt`, `burst_done[c] <= 1`, `cnt <= 0`.
  - `sop` and `burst_done` are otherwise 0.
- **Channel independence.** Channels are fully independent. Different latencies may overlap bursts across channels.

## Timing
- **Reset values.** Every output, `s1`, `s2`, `dly`, `cnt` and the FSMs are 0/IDLE. `lat_q` holds `tlat` as sampled during reset, and `lat_err` reflects it.
- **Latency.**
  - Let e be the first edge that samples `adc_rd`=1. Then `s2`=1 after e+1, `dly[0]`=1 after e+2, and `dat_valid[c]`=1 after edge e+L+2.
  - The valid window is exactly as long as the synchronised `adc_rd` high time.
  - `dat_out` lags `adc_data` by 1 cycle.
- **Burst end.** `burst_done` asserts on the same edge that `dat_valid` falls.
- **Back-to-back bursts.** A single-cycle gap in `adc_rd` yields one `burst_done` pulse followed by `sop` one cycle later. No merge occurs.
- **Reset mid-burst.** Everything clears on the next edge. No `burst_done` is issued for the aborted burst.

## Structure
- Package `adc_align_pkg` holds:
  - localparams `MAX_LAT_DEF`=64 and `LAT_W_DEF`=7;
  - the lane state encoding `LANE_IDLE`/`LANE_RUN`;
  - a function `lat_ok(lat, max)`.
- Sub-module `adc_valid_lane`, generated N_CH times, contains tap selection, the shadow register, the FSM and the counter.
- The top level owns the synchroniser and the shared delay line.

## Test plan
- **Basic delay.** `tlat`={21,32}; drive `adc_rd` high for 100 cycles. Expect ch0 valid rising at e+23 and ch1 at e+34, each 100 cycles wide; `sop` once per channel; `burst_len`=100 with `burst_done` on the falling edge.
- **Range errors.** `tlat`={0,65}: expect `lat_err`=2'b11 and no valid/sop/done for any `adc_rd`. `tlat`=64: expect valid at e+66.
- **Mid-burst latency change.** Change `tlat` from 25 to 30 mid-burst: the current burst keeps latency 25 and length is unchanged; the next burst uses 30.
- **Back-to-back bursts.** `adc_rd` high 10, low 1, high 10: expect two `sop` pulses, two `burst_done` pulses, and `burst_len`=10 both times.
- **Reset and saturation.** Assert `rst` mid-burst: all outputs are 0 the next cycle and no `burst_done` fires. Separately, with CW=4, a 40-cycle burst gives `burst_len`=15.
